// File: rtl/fetch_queue.sv
// Elastic {pc, instr} buffer between instruction fetch and decode, with flush.
// Define FETCH_QUEUE_BYPASS_EN to compile in the zero-latency empty-queue bypass.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_push;
    logic             w_pop;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);

    // Handshake readies depend only on count and flush, never on the partner's valid/ready.
    assign in_ready = !flush && !w_full;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass  = w_empty && in_valid && !flush;
    assign out_valid = !flush && (!w_empty || in_valid);
`else
    assign w_bypass  = 1'b0;
    assign out_valid = !flush && !w_empty;
`endif

    // A bypassed entry consumed this cycle is neither written nor popped from storage.
    assign w_push = in_valid && in_ready && !(w_bypass && out_ready);
    assign w_pop  = out_valid && out_ready && !w_bypass;

    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no latch is inferred.
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            if (w_bypass) begin
                out_pc    = in_pc;
                out_instr = in_instr;
            end else begin
                out_pc    = r_mem_pc[r_rp];
                out_instr = r_mem_instr[r_rp];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale slots are unreachable because count and pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wp]    <= in_pc;
            r_mem_instr[r_wp] <= in_instr;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4, default build without bypass).
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic             out_ready;
    logic             flush;
    logic [CNT_W-1:0] count;

    int n_total = 0;
    int n_pass  = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic [31:0] instr);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset then idle
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pc",    out_pc,         32'd0);
        check("rst_out_instr", out_instr,      32'd0);
        check("rst_count",     32'(count),     32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);

        // Streaming: PCs 0x0..0xC with out_ready held high, head appears one cycle after push
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i < 4);
            in_pc    = 32'(4 * i);
            in_instr = 32'(8'hA0 + i);
            #1;
            check("strm_out_valid", 32'(out_valid), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                check("strm_out_pc",    out_pc,    32'(4 * (i - 1)));
                check("strm_out_instr", out_instr, 32'(8'hA0 + i - 1));
            end
            check("strm_in_ready", 32'(in_ready), 32'd1);
            tick();
            check("strm_count", 32'(count), (i < 4) ? 32'd1 : 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Full / backpressure: five pushes into a four-entry queue
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_pc    = 32'(4 * i);
            in_instr = 32'(8'hB0 + i);
            #1;
            check("full_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
            tick();
            check("full_count", 32'(count), (i < 4) ? 32'(i + 1) : 32'd4);
        end
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            int exp_cnt [5] = '{3, 3, 2, 1, 0};
            in_valid = (j <= 1);
            in_pc    = 32'h10;
            in_instr = 32'hB4;
            #1;
            check("drain_out_pc",    out_pc,         32'(4 * j));
            check("drain_out_instr", out_instr,      32'(8'hB0 + j));
            check("drain_in_ready",  32'(in_ready),  (j == 0) ? 32'd0 : 32'd1);
            tick();
            check("drain_count", 32'(count), 32'(exp_cnt[j]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Wrap-around: one resident entry while ten push/pop pairs cross the pointer wrap
        push_entry(32'h100, 32'hC0);
        check("wrap_fill_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_pc    = 32'h104 + 32'(4 * k);
            in_instr = 32'hC1 + 32'(k);
            #1;
            check("wrap_out_pc", out_pc, 32'h100 + 32'(4 * k));
            tick();
            check("wrap_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        #1;
        check("wrap_last_pc",    out_pc,    32'h128);
        check("wrap_last_instr", out_instr, 32'hCA);
        tick();
        check("wrap_empty_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Flush mid-stream with an entry presented on the flush cycle
        push_entry(32'h20, 32'hD0);
        push_entry(32'h24, 32'hD1);
        push_entry(32'h28, 32'hD2);
        check("flush_pre_count", 32'(count), 32'd3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_pc    = 32'h40;
        in_instr = 32'hE0;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready",  32'(in_ready),  32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_out_pc",    out_pc,         32'd0);
        tick();
        flush     = 1'b0;
        out_ready = 1'b0;
        check("flush_post_count", 32'(count), 32'd0);
        #1;
        check("flush_rep_in_ready",  32'(in_ready),  32'd1);
        check("flush_rep_out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        check("flush_head_count", 32'(count),     32'd1);
        check("flush_head_valid", 32'(out_valid), 32'd1);
        check("flush_head_pc",    out_pc,         32'h40);
        check("flush_head_instr", out_instr,      32'hE0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("flush_drain_count", 32'(count), 32'd0);

        // Asynchronous reset between edges with three entries stored
        push_entry(32'h50, 32'hF0);
        push_entry(32'h54, 32'hF1);
        push_entry(32'h58, 32'hF2);
        check("arst_pre_count", 32'(count), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count",     32'(count),     32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_pc",    out_pc,         32'd0);
        #1;
        reset = 1'b1;
        tick();
        check("arst_post_count",    32'(count),    32'd0);
        check("arst_post_in_ready", 32'(in_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
